// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter. A DEPTH-entry FIFO is built with
// UART_TX_FIFO_EN defined; otherwise a single holding register is used.
module uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0300,
  parameter int unsigned DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rd,
  input  logic [31:0] i_addr,
  input  logic        i_wr,
  input  logic [3:0]  i_wrmask,
  input  logic [31:0] i_data,
  output logic        o_rd_valid,
  output logic        o_wr_valid,
  output logic [31:0] o_data,
  output logic        o_tx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic        hit, resp_busy, rd_acc, wr_acc;
  logic        push_req, push, pop, ovf_set;
  logic [1:0]  sel;
  logic [15:0] div, div_q, cnt;
  logic [1:0]  state;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        tx_q, ovf, busy;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_count, fifo_head;
  logic [31:0] status, rdata;
  logic        unused_bits;

  assign hit       = (i_addr[31:4] == BASE_ADDR[31:4]);
  assign sel       = i_addr[3:2];
  // One request per response pulse: a held strobe is not re-accepted.
  assign resp_busy = o_rd_valid | o_wr_valid;
  assign rd_acc    = i_rd & hit & ~resp_busy;
  assign wr_acc    = i_wr & hit & ~resp_busy;

  assign push_req = wr_acc & (sel == 2'd0) & i_wrmask[0];
  assign pop      = (state == S_IDLE) & ~fifo_empty;
  assign push     = push_req & (~fifo_full | pop);
  assign ovf_set  = push_req & fifo_full & ~pop;

  assign unused_bits = &{1'b0, i_addr[1:0], i_data[31:16], DEPTH[0]};

`ifdef UART_TX_FIFO_EN
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= i_data[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign fifo_count = 8'(count);
  assign fifo_head  = mem[rptr];
`else
  logic [7:0] hold;
  logic       hold_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (push) begin
      hold       <= i_data[7:0];
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign fifo_full  = hold_valid;
  assign fifo_empty = ~hold_valid;
  assign fifo_count = {7'd0, hold_valid};
  assign fifo_head  = hold;
`endif

  assign busy   = (state != S_IDLE) | ~fifo_empty;
  assign status = {16'd0, fifo_count, 4'd0, ovf, fifo_empty, fifo_full, busy};

  always_comb begin
    rdata = '0;
    case (sel)
      2'd1:    rdata = status;
      2'd2:    rdata = {16'd0, div};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_valid <= 1'b0;
      o_wr_valid <= 1'b0;
      o_data     <= '0;
      div        <= DEFAULT_DIV;
      ovf        <= 1'b0;
    end else begin
      o_rd_valid <= rd_acc;
      o_wr_valid <= wr_acc;
      o_data     <= rd_acc ? rdata : '0;
      if (wr_acc && sel == 2'd2) begin
        if (i_wrmask[0]) div[7:0]  <= i_data[7:0];
        if (i_wrmask[1]) div[15:8] <= i_data[15:8];
      end
      // A fresh overflow beats the clear-on-read of STATUS.
      if (ovf_set)                     ovf <= 1'b1;
      else if (rd_acc && sel == 2'd1)  ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tx_q    <= 1'b1;
      shreg   <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      div_q   <= DEFAULT_DIV;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg <= fifo_head;
            cnt   <= div;
            div_q <= div;
            tx_q  <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == 16'd0) begin
            cnt     <= div_q;
            tx_q    <= shreg[0];
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (cnt == 16'd0) begin
            cnt <= div_q;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= S_STOP;
            end else begin
              shreg   <= shreg >> 1;
              tx_q    <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (cnt == 16'd0) state <= S_IDLE;
          else              cnt   <= cnt - 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_tx = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table-driven register accesses plus
// hand-written frame, overflow, held-write, DIV-change and reset sequences.
module tb_uart_tx;

`ifdef UART_TX_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  localparam logic [31:0] A_DATA = 32'h4000_0300;
  localparam logic [31:0] A_STAT = 32'h4000_0304;
  localparam logic [31:0] A_DIV  = 32'h4000_0308;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_rd, i_wr;
  logic [31:0] i_addr, i_data;
  logic [3:0]  i_wrmask;
  logic        o_rd_valid, o_wr_valid, o_tx;
  logic [31:0] o_data;

  int checks = 0;
  int errors = 0;

  uart_tx #(
    .BASE_ADDR(32'h4000_0300),
    .DEPTH(8),
    .DEFAULT_DIV(16'd103)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_rd(i_rd), .i_addr(i_addr), .i_wr(i_wr),
    .i_wrmask(i_wrmask), .i_data(i_data), .o_rd_valid(o_rd_valid),
    .o_wr_valid(o_wr_valid), .o_data(o_data), .o_tx(o_tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        exp_rv;
    logic        exp_wv;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic bsy, input int count, input logic ov);
    return {16'd0, 8'(count), 4'd0, ov, (count == 0), (count == CAP), bsy};
  endfunction

  // Request in the current cycle, sample the response one cycle later,
  // then leave one quiet cycle so the next request is accepted at once.
  task automatic bus(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [3:0] mask, input logic [31:0] data,
                     output logic rv, output logic wv, output logic [31:0] rdata);
    i_rd = rd; i_wr = wr; i_addr = addr; i_wrmask = mask; i_data = data;
    @(posedge clk); #1;
    rv = o_rd_valid; wv = o_wr_valid; rdata = o_data;
    i_rd = 1'b0; i_wr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input string name);
    logic rv, wv;
    logic [31:0] rd;
    bus(1'b0, 1'b1, addr, mask, data, rv, wv, rd);
    chk({name, " wv"}, 32'(wv), 32'd1);
  endtask

  task automatic rd_reg(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic rv, wv;
    logic [31:0] rd;
    bus(1'b1, 1'b0, addr, 4'h0, 32'h0, rv, wv, rd);
    chk({name, " rv"}, 32'(rv), 32'd1);
    chk({name, " data"}, rd, exp);
  endtask

  // Entered on the first START cycle; leaves on the first cycle after STOP.
  task automatic expect_frame(input logic [7:0] b, input int div, input string tag);
    int per;
    int slot;
    logic e;
    per = div + 1;
    for (int k = 0; k < 10 * per; k++) begin
      slot = k / per;
      if (slot == 0)      e = 1'b0;
      else if (slot == 9) e = 1'b1;
      else                e = b[slot-1];
      chk($sformatf("%s tx cyc%0d", tag, k), 32'(o_tx), 32'(e));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic rv, wv;
    logic [31:0] rd;
    logic [7:0] bytes[10];

    rst_n = 1'b0; i_rd = 1'b0; i_wr = 1'b0; i_addr = '0; i_wrmask = '0; i_data = '0;
    vecs[0]  = '{1'b1, 1'b0, A_STAT,        4'h0, 32'h0,         1'b1, 1'b0, 32'h0000_0004};
    vecs[1]  = '{1'b1, 1'b0, A_DIV,         4'h0, 32'h0,         1'b1, 1'b0, 32'h0000_0067};
    vecs[2]  = '{1'b1, 1'b0, A_DATA,        4'h0, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h4000_030C, 4'h0, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h4000_0404, 4'h0, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, A_DIV,         4'b0010, 32'h0000_1200, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, A_DIV,         4'h0, 32'h0,         1'b1, 1'b0, 32'h0000_1267};
    vecs[7]  = '{1'b0, 1'b1, A_DIV,         4'b0011, 32'hABCD_0003, 1'b0, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, A_DIV,         4'h0, 32'h0,         1'b1, 1'b0, 32'h0000_0003};
    vecs[9]  = '{1'b0, 1'b1, 32'h4000_030C, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b0, A_DIV,         4'h0, 32'h0,         1'b1, 1'b0, 32'h0000_0003};
    vecs[11] = '{1'b0, 1'b1, 32'h4000_0208, 4'hF, 32'h0000_0055, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h4000_030A, 4'h0, 32'h0,         1'b1, 1'b0, 32'h0000_0003};
    vecs[13] = '{1'b0, 1'b1, A_DATA,        4'b1110, 32'h0000_0077, 1'b0, 1'b1, 32'h0};
    vecs[14] = '{1'b1, 1'b0, A_STAT,        4'h0, 32'h0,         1'b1, 1'b0, 32'h0000_0004};
    vecs[15] = '{1'b1, 1'b0, 32'h4000_0314, 4'h0, 32'h0,         1'b0, 1'b0, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset tx", 32'(o_tx), 32'd1);
    chk("reset rv", 32'(o_rd_valid), 32'd0);
    chk("reset wv", 32'(o_wr_valid), 32'd0);
    chk("reset data", o_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      bus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].mask, vecs[i].data, rv, wv, rd);
      chk($sformatf("vec%0d rv", i), 32'(rv), 32'(vecs[i].exp_rv));
      chk($sformatf("vec%0d wv", i), 32'(wv), 32'(vecs[i].exp_wv));
      chk($sformatf("vec%0d data", i), rd, vecs[i].exp_data);
    end

    // Single frame, DIV=3: o_tx falls two cycles after the request.
    i_wr = 1'b1; i_addr = A_DATA; i_wrmask = 4'h1; i_data = 32'h0000_00A5;
    @(posedge clk); #1;
    chk("a5 wv", 32'(o_wr_valid), 32'd1);
    chk("a5 tx before fall", 32'(o_tx), 32'd1);
    i_wr = 1'b0;
    @(posedge clk); #1;
    chk("a5 tx fall", 32'(o_tx), 32'd0);
    expect_frame(8'hA5, 3, "a5");
    chk("a5 idle after", 32'(o_tx), 32'd1);
    rd_reg(A_STAT, 32'h4, "a5 status");

    // Write strobe held across the response cycle pushes a single byte.
    i_wr = 1'b1; i_addr = A_DATA; i_wrmask = 4'h1; i_data = 32'h0000_005A;
    @(posedge clk); #1;
    chk("held wv1", 32'(o_wr_valid), 32'd1);
    @(posedge clk); #1;
    chk("held wv2", 32'(o_wr_valid), 32'd0);
    i_wr = 1'b0;
    expect_frame(8'h5A, 3, "held");
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("held no second frame %0d", k), 32'(o_tx), 32'd1);
      @(posedge clk); #1;
    end
    rd_reg(A_STAT, 32'h4, "held status");

    // DIV written mid-frame only affects the following frame.
    wr_reg(A_DATA, 4'h1, 32'h3C, "f1 push");
    fork
      begin
        expect_frame(8'h3C, 3, "f1");
        chk("f1 gap", 32'(o_tx), 32'd1);
        @(posedge clk); #1;
        expect_frame(8'h96, 1, "f2");
        chk("f2 idle after", 32'(o_tx), 32'd1);
      end
      begin
        wr_reg(A_DIV, 4'h3, 32'h1, "divchg div");
        wr_reg(A_DATA, 4'h1, 32'h96, "divchg push");
        rd_reg(A_STAT, exp_status(1'b1, 1, 1'b0), "divchg status");
        rd_reg(A_DIV, 32'h1, "divchg divread");
      end
    join
    rd_reg(A_STAT, 32'h4, "divchg status end");

    // Overflow: fill the buffer while the first frame is in flight.
    for (int i = 0; i < 10; i++) bytes[i] = 8'(8'h11 * (i + 1));
    wr_reg(A_DIV, 4'h3, 32'h7, "ovf div");
    wr_reg(A_DATA, 4'h1, 32'(bytes[0]), "ovf push0");
    fork
      begin
        for (int i = 0; i <= CAP; i++) begin
          expect_frame(bytes[i], 7, $sformatf("ovf f%0d", i));
          chk($sformatf("ovf gap%0d", i), 32'(o_tx), 32'd1);
          @(posedge clk); #1;
        end
        for (int k = 0; k < 20; k++) begin
          chk($sformatf("ovf dropped byte silent %0d", k), 32'(o_tx), 32'd1);
          @(posedge clk); #1;
        end
      end
      begin
        for (int i = 1; i <= CAP + 1; i++)
          wr_reg(A_DATA, 4'h1, 32'(bytes[i]), $sformatf("ovf push%0d", i));
        rd_reg(A_STAT, exp_status(1'b1, CAP, 1'b1), "ovf status1");
        rd_reg(A_STAT, exp_status(1'b1, CAP, 1'b0), "ovf status2");
      end
    join
    rd_reg(A_STAT, 32'h4, "ovf status end");

    // Minimum bit period.
    wr_reg(A_DIV, 4'h3, 32'h0, "div0 div");
    wr_reg(A_DATA, 4'h1, 32'h6B, "div0 push");
    expect_frame(8'h6B, 0, "div0");
    chk("div0 idle after", 32'(o_tx), 32'd1);

    // Asynchronous reset in the middle of a frame.
    wr_reg(A_DIV, 4'h3, 32'h7, "rst div");
    wr_reg(A_DATA, 4'h1, 32'h00, "rst push");
    repeat (12) begin @(posedge clk); #1; end
    chk("rst midframe low", 32'(o_tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst tx immediate", 32'(o_tx), 32'd1);
    chk("rst rv", 32'(o_rd_valid), 32'd0);
    chk("rst data", o_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_reg(A_STAT, 32'h4, "rst status");
    rd_reg(A_DIV, 32'd103, "rst div read");
    chk("rst tx idle", 32'(o_tx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
